// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard sequencer and the forwarding unit.
package hazard_pkg;

    localparam int unsigned REG_W_DEF = 3;
    localparam int unsigned INSTR_W   = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for pipeline performance counters.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer: load-use, taken branch and data-memory wait handling,
// with a memory-wait watchdog and a stall-cycle counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W   = REG_W_DEF,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16,
    parameter bit          R0_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_ex_memRead,
    input  logic [REG_W-1:0] id_ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             freeze,
    output logic             mem_abort,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              mem_err_q;

    logic rs_hit_c, rt_hit_c, load_use_c, apply_run_c;
    logic pc_write_c, if_id_write_c, if_id_flush_c, id_ex_flush_c, freeze_c, abort_c;

    // Load-use comparator; a load into hardwired r0 never creates a dependency.
    assign rs_hit_c   = id_uses_rs && (id_rs == id_ex_rt);
    assign rt_hit_c   = id_uses_rt && (id_rt == id_ex_rt);
    assign load_use_c = id_ex_memRead && (rs_hit_c || rt_hit_c)
                        && !(R0_ZERO && (id_ex_rt == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_q | abort_c;
        end
    end

    // Next state and Mealy output decode.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        apply_run_c   = 1'b0;
        pc_write_c    = 1'b0;
        if_id_write_c = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        freeze_c      = 1'b0;
        abort_c       = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    freeze_c = 1'b1;
                    state_d  = MEM_WAIT;
                    wait_d   = WAIT_W'(1);
                end else begin
                    apply_run_c = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d     = RUN;
                    wait_d      = '0;
                    apply_run_c = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    abort_c  = 1'b1;
                    freeze_c = 1'b1;
                    state_d  = RUN;
                    wait_d   = '0;
                end else begin
                    freeze_c = 1'b1;
                    wait_d   = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase

        // Branch beats load-use: the stalled instruction is squashed anyway.
        if (apply_run_c) begin
            if (ex_branch_taken) begin
                pc_write_c    = 1'b1;
                if_id_write_c = 1'b1;
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
            end else if (load_use_c) begin
                id_ex_flush_c = 1'b1;
            end else begin
                pc_write_c    = 1'b1;
                if_id_write_c = 1'b1;
            end
        end
    end

    // Every output is held low while reset is asserted.
    assign pc_write    = rst_n & pc_write_c;
    assign if_id_write = rst_n & if_id_write_c;
    assign if_id_flush = rst_n & if_id_flush_c;
    assign id_ex_flush = rst_n & id_ex_flush_c;
    assign freeze      = rst_n & freeze_c;
    assign mem_abort   = rst_n & abort_c;
    assign mem_err     = mem_err_q;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (~pc_write),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: default instance, a TIMEOUT=4 instance and a 2-bit counter instance.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] id_rs, id_rt, id_ex_rt;
    logic       id_uses_rs, id_uses_rt, id_ex_memRead, ex_branch_taken;
    logic       mem_req, mem_ready, to_mem_req;

    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, freeze, mem_abort, mem_err;
    logic [15:0] stall_cnt;
    logic        to_pc_write, to_if_id_write, to_if_id_flush, to_id_ex_flush, to_freeze, to_abort, to_err;
    logic [15:0] to_stall_cnt;
    logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_freeze, s_abort, s_err;
    logic [1:0]  s_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_ex_memRead(id_ex_memRead), .id_ex_rt(id_ex_rt),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .freeze(freeze), .mem_abort(mem_abort),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.TIMEOUT(4)) u_to (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_ex_memRead(id_ex_memRead), .id_ex_rt(id_ex_rt),
        .ex_branch_taken(ex_branch_taken), .mem_req(to_mem_req), .mem_ready(mem_ready),
        .pc_write(to_pc_write), .if_id_write(to_if_id_write), .if_id_flush(to_if_id_flush),
        .id_ex_flush(to_id_ex_flush), .freeze(to_freeze), .mem_abort(to_abort),
        .mem_err(to_err), .stall_cnt(to_stall_cnt)
    );

    hazard_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_ex_memRead(id_ex_memRead), .id_ex_rt(id_ex_rt),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
        .id_ex_flush(s_id_ex_flush), .freeze(s_freeze), .mem_abort(s_abort),
        .mem_err(s_err), .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_id();
        id_rs = 3'd0; id_rt = 3'd0; id_ex_rt = 3'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_ex_memRead = 1'b0;
        ex_branch_taken = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_id();
        mem_req = 1'b0; mem_ready = 1'b0; to_mem_req = 1'b0;

        // Reset values
        #3;
        chk("rst_pc_write", 32'(pc_write), 32'd0);
        chk("rst_if_id_write", 32'(if_id_write), 32'd0);
        chk("rst_freeze", 32'(freeze), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);

        @(negedge clk); rst_n = 1'b1; #2;
        chk("run_pc_write", 32'(pc_write), 32'd1);
        chk("run_if_id_write", 32'(if_id_write), 32'd1);

        // Load-use on rs
        @(negedge clk);
        id_ex_memRead = 1'b1; id_ex_rt = 3'd3; id_rs = 3'd3; id_uses_rs = 1'b1; #2;
        chk("lu_pc_write", 32'(pc_write), 32'd0);
        chk("lu_if_id_write", 32'(if_id_write), 32'd0);
        chk("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
        chk("lu_if_id_flush", 32'(if_id_flush), 32'd0);
        chk("lu_freeze", 32'(freeze), 32'd0);
        @(negedge clk); clear_id(); #2;
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        chk("lu_release", 32'(pc_write), 32'd1);

        // Load-use on rt
        @(negedge clk);
        id_ex_memRead = 1'b1; id_ex_rt = 3'd5; id_rt = 3'd5; id_uses_rt = 1'b1; id_rs = 3'd5; #2;
        chk("lu_rt_pc_write", 32'(pc_write), 32'd0);

        // Matching registers that are not read do not stall
        @(negedge clk);
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; #2;
        chk("nouse_pc_write", 32'(pc_write), 32'd1);
        chk("nouse_stall_cnt", 32'(stall_cnt), 32'd2);

        // r0 mask
        @(negedge clk);
        id_ex_rt = 3'd0; id_rs = 3'd0; id_rt = 3'd0; id_uses_rs = 1'b1; id_uses_rt = 1'b1; #2;
        chk("r0_pc_write", 32'(pc_write), 32'd1);
        chk("r0_id_ex_flush", 32'(id_ex_flush), 32'd0);

        // Branch together with load-use
        @(negedge clk);
        id_ex_rt = 3'd3; id_rs = 3'd3; id_uses_rt = 1'b0; ex_branch_taken = 1'b1; #2;
        chk("br_pc_write", 32'(pc_write), 32'd1);
        chk("br_if_id_write", 32'(if_id_write), 32'd1);
        chk("br_if_id_flush", 32'(if_id_flush), 32'd1);
        chk("br_id_ex_flush", 32'(id_ex_flush), 32'd1);
        @(negedge clk); clear_id(); #2;
        chk("br_stall_cnt", 32'(stall_cnt), 32'd2);

        // Memory wait of four cycles; branch while waiting is ignored
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = (i == 2); #2;
            chk("mw_freeze", 32'(freeze), 32'd1);
            chk("mw_pc_write", 32'(pc_write), 32'd0);
            chk("mw_if_id_flush", 32'(if_id_flush), 32'd0);
            chk("mw_abort", 32'(mem_abort), 32'd0);
        end
        @(negedge clk); mem_ready = 1'b1; ex_branch_taken = 1'b1; #2;
        chk("mw_rel_freeze", 32'(freeze), 32'd0);
        chk("mw_rel_pc_write", 32'(pc_write), 32'd1);
        chk("mw_rel_if_id_flush", 32'(if_id_flush), 32'd1);
        @(negedge clk); clear_id(); mem_req = 1'b0; mem_ready = 1'b0; #2;
        chk("mw_stall_cnt", 32'(stall_cnt), 32'd6);
        chk("sat_stall_cnt", 32'(s_stall_cnt), 32'd3);
        chk("mw_mem_err", 32'(mem_err), 32'd0);

        // Watchdog expiry with TIMEOUT=4
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); to_mem_req = 1'b1; #2;
            chk("to_wait_abort", 32'(to_abort), 32'd0);
            chk("to_wait_freeze", 32'(to_freeze), 32'd1);
        end
        @(negedge clk); #2;
        chk("to_abort", 32'(to_abort), 32'd1);
        chk("to_abort_freeze", 32'(to_freeze), 32'd1);
        chk("to_abort_pc_write", 32'(to_pc_write), 32'd0);
        chk("to_err_pre", 32'(to_err), 32'd0);
        @(negedge clk); to_mem_req = 1'b0; #2;
        chk("to_abort_pulse", 32'(to_abort), 32'd0);
        chk("to_err", 32'(to_err), 32'd1);
        chk("to_run_pc_write", 32'(to_pc_write), 32'd1);
        @(negedge clk); #2;
        chk("to_err_sticky", 32'(to_err), 32'd1);

        // Ready on the expiry cycle is a success
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); to_mem_req = 1'b1; mem_ready = 1'b0; #2;
        end
        @(negedge clk); mem_ready = 1'b1; #2;
        chk("to_edge_abort", 32'(to_abort), 32'd0);
        chk("to_edge_freeze", 32'(to_freeze), 32'd0);
        chk("to_edge_pc_write", 32'(to_pc_write), 32'd1);
        @(negedge clk); to_mem_req = 1'b0; mem_ready = 1'b0; #2;
        chk("to_quiet_stall_cnt", 32'(stall_cnt), 32'd6);

        // Reset in the second MEM_WAIT cycle
        @(negedge clk); mem_req = 1'b1; #2;
        chk("rw_freeze1", 32'(freeze), 32'd1);
        @(negedge clk); #2;
        chk("rw_freeze2", 32'(freeze), 32'd1);
        #1 rst_n = 1'b0; #1;
        chk("rw_freeze", 32'(freeze), 32'd0);
        chk("rw_pc_write", 32'(pc_write), 32'd0);
        chk("rw_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rw_to_err", 32'(to_err), 32'd0);
        @(negedge clk); rst_n = 1'b1; mem_req = 1'b0; #2;
        chk("rw_run_pc_write", 32'(pc_write), 32'd1);
        chk("rw_run_freeze", 32'(freeze), 32'd0);
        @(negedge clk); mem_req = 1'b1; #2;
        chk("rw_rule1_freeze", 32'(freeze), 32'd1);
        chk("rw_rule1_abort", 32'(mem_abort), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
